checkbits_reporter: RTL and testbench

CHECKBITS_REPORTER -- requirements
Module: checkbits_reporter

---
 rtl/checkbits_pkg.sv | 19 +
 rtl/checkbits_reporter_fifo.sv | 66 ++++++
 rtl/checkbits_reporter.sv | 185 ++++++++++++++++++
 tb/tb_checkbits_reporter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/checkbits_pkg.sv
// Shared definitions for the checkbits reporter: sequencer states, default
// start/end marker values and the width of one buffered stream word
// ({last, data}).
package checkbits_pkg;

   localparam logic [15:0] START_MARK_DEF = 16'h00A5;
   localparam logic [15:0] END_MARK_DEF   = 16'h005A;
   localparam int          FIFO_W         = 17;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_SHOW,
      ST_END,
      ST_DONE
   } state_t;

endpackage

// File: rtl/checkbits_reporter_fifo.sv
// sync_fifo: single-clock FIFO with synchronous active-low reset.
//   clk_sys  : clock
//   rst_b    : synchronous active-low reset, empties the FIFO
//   wr_en    : push wr_data (ignored when full)
//   rd_en    : pop head (ignored when empty)
//   rd_data  : current head entry, valid while !empty
//   full     : DEPTH entries held (registered count)
//   empty    : no entries held (registered count)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk_sys) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/checkbits_reporter.sv
// checkbits_reporter: buffers the matmul result stream and replays it on the
// mprj_io[31:16] check pins, framed by start/end markers, each value held for
// a programmable number of cycles.
//   axis_clk, axis_rst_n : clock, synchronous active-low reset
//   start                : one-cycle pulse, begins a report (IDLE/DONE only)
//   hold_cycles          : cycles each value is held (0 treated as 1)
//   s_valid/s_ready/s_data/s_last : result stream input
//   checkbits, io_oeb    : pin value and output-enable-bar
//   busy, done           : sequence status
//   cyc_cnt              : cycles spent from START entry to DONE entry
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | after reset, pins at 0, waiting for start
// ST_START | showing START_MARK for the hold period
// ST_WAIT  | FIFO empty, keep last value until a word arrives
// ST_SHOW  | showing a popped data word for the hold period
// ST_END   | showing END_MARK for the hold period
// ST_DONE  | sequence finished, END_MARK stays on the pins
module checkbits_reporter
   import checkbits_pkg::*;
#(
   parameter int          DEPTH      = 4,
   parameter int          HOLD_W     = 16,
   parameter logic [15:0] START_MARK = START_MARK_DEF,
   parameter logic [15:0] END_MARK   = END_MARK_DEF
) (
   input  logic              axis_clk,
   input  logic              axis_rst_n,
   input  logic              start,
   input  logic [HOLD_W-1:0] hold_cycles,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [15:0]       s_data,
   input  logic              s_last,
   output logic [15:0]       checkbits,
   output logic [15:0]       io_oeb,
   output logic              busy,
   output logic              done,
   output logic [31:0]       cyc_cnt
);

   state_t              state;
   state_t              state_nx;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [HOLD_W-1:0]   hold_load;
   logic                hold_ld;
   logic                hold_dec;
   logic                hold_done;
   logic [15:0]         cb_nx;
   logic                last_q;
   logic                last_nx;
   logic                cnt_clr;
   logic                take_next;
   logic                ready_q;
   logic                push;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [FIFO_W-1:0]   fifo_rd_data;

   // ready_q keeps s_ready low through reset and raises it one edge later
   assign s_ready = ready_q && !fifo_full;
   assign push    = s_valid && s_ready;

   sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_sys (axis_clk),
      .rst_b   (axis_rst_n),
      .wr_en   (push),
      .wr_data ({s_last, s_data}),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Hold timer is a down-counter loaded with max(hold,1)-1 on state entry;
   // the hold ends in the cycle it reads zero.
   assign hold_load = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);
   assign hold_done = (hold_cnt == '0);

   assign busy = (state == ST_START) || (state == ST_WAIT) ||
                 (state == ST_SHOW)  || (state == ST_END);
   assign done = (state == ST_DONE);

   // When a hold expires and a word is already buffered, the pop happens in
   // that same cycle so WAIT costs no time; WAIT is only occupied while the
   // FIFO is empty.
   always_comb begin
      state_nx  = state;
      cb_nx     = checkbits;
      last_nx   = last_q;
      hold_ld   = 1'b0;
      hold_dec  = 1'b0;
      cnt_clr   = 1'b0;
      pop       = 1'b0;
      take_next = 1'b0;

      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nx = ST_START;
               cb_nx    = START_MARK;
               hold_ld  = 1'b1;
               cnt_clr  = 1'b1;
            end
         end
         ST_START: begin
            if (hold_done) begin
               take_next = 1'b1;
            end else begin
               hold_dec = 1'b1;
            end
         end
         ST_WAIT: begin
            take_next = 1'b1;
         end
         ST_SHOW: begin
            if (!hold_done) begin
               hold_dec = 1'b1;
            end else if (last_q) begin
               state_nx = ST_END;
               cb_nx    = END_MARK;
               hold_ld  = 1'b1;
            end else begin
               take_next = 1'b1;
            end
         end
         ST_END: begin
            if (hold_done) begin
               state_nx = ST_DONE;
            end else begin
               hold_dec = 1'b1;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase

      if (take_next) begin
         if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = ST_SHOW;
            cb_nx    = fifo_rd_data[15:0];
            last_nx  = fifo_rd_data[16];
            hold_ld  = 1'b1;
         end else begin
            state_nx = ST_WAIT;
         end
      end
   end

   always_ff @(posedge axis_clk) begin
      if (!axis_rst_n) begin
         state     <= ST_IDLE;
         checkbits <= '0;
         last_q    <= 1'b0;
         hold_cnt  <= '0;
         cyc_cnt   <= '0;
         ready_q   <= 1'b0;
         io_oeb    <= 16'hFFFF;
      end else begin
         state     <= state_nx;
         checkbits <= cb_nx;
         last_q    <= last_nx;
         ready_q   <= 1'b1;
         io_oeb    <= 16'h0000;
         if (hold_ld) begin
            hold_cnt <= hold_load;
         end else if (hold_dec) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
         end
         if (cnt_clr) begin
            cyc_cnt <= '0;
         end else if (busy && (cyc_cnt != 32'hFFFF_FFFF)) begin
            cyc_cnt <= cyc_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_checkbits_reporter.sv
`timescale 1ns/1ps
module tb_checkbits_reporter;

   localparam int DEPTH  = 4;
   localparam int HOLD_W = 16;

   logic              axis_clk    = 1'b0;
   logic              axis_rst_n  = 1'b0;
   logic              start       = 1'b0;
   logic [HOLD_W-1:0] hold_cycles = '0;
   logic              s_valid     = 1'b0;
   logic              s_ready;
   logic [15:0]       s_data      = '0;
   logic              s_last      = 1'b0;
   logic [15:0]       checkbits;
   logic [15:0]       io_oeb;
   logic              busy;
   logic              done;
   logic [31:0]       cyc_cnt;

   always #5 axis_clk = ~axis_clk;

   checkbits_reporter #(
      .DEPTH      (DEPTH),
      .HOLD_W     (HOLD_W),
      .START_MARK (16'h00A5),
      .END_MARK   (16'h005A)
   ) dut (
      .axis_clk    (axis_clk),
      .axis_rst_n  (axis_rst_n),
      .start       (start),
      .hold_cycles (hold_cycles),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .checkbits   (checkbits),
      .io_oeb      (io_oeb),
      .busy        (busy),
      .done        (done),
      .cyc_cnt     (cyc_cnt)
   );

   typedef struct {
      int               hold;
      int               n;
      logic [3:0][15:0] w;
      logic [31:0]      exp_cyc;
   } vec_t;

   vec_t        vecs [5];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          nbusy;
   logic [15:0] trace [$];
   logic [15:0] runs  [$];
   logic [15:0] exp_q [$];
   logic [15:0] wq    [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge axis_clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] d, input logic l);
      logic acc;
      acc     = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      for (int i = 0; i < 100 && !acc; i++) begin
         acc = s_ready;
         tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      check("push_accept", {31'd0, acc}, 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Records checkbits on every busy cycle until done rises.
   task automatic monitor(input int budget);
      trace.delete();
      nbusy = 0;
      for (int i = 0; i < budget && !done; i++) begin
         if (busy) begin
            trace.push_back(checkbits);
            nbusy++;
         end
         tick();
      end
      check("reach_done", {31'd0, done}, 32'd1);
   endtask

   // Reference: every value (start mark, each word, end mark) is shown for
   // max(hold,1) consecutive cycles when the words are already buffered.
   task automatic build_expected(input int h);
      int hh;
      hh = (h == 0) ? 1 : h;
      exp_q.delete();
      repeat (hh) exp_q.push_back(16'h00A5);
      foreach (wq[k]) repeat (hh) exp_q.push_back(wq[k]);
      repeat (hh) exp_q.push_back(16'h005A);
   endtask

   task automatic collapse();
      runs.delete();
      foreach (trace[k]) begin
         if (runs.size() == 0 || runs[runs.size()-1] != trace[k]) runs.push_back(trace[k]);
      end
   endtask

   task automatic compare_trace(input string name);
      check({name, "_len"}, trace.size(), exp_q.size());
      for (int k = 0; k < trace.size() && k < exp_q.size(); k++) begin
         check({name, "_val"}, {16'd0, trace[k]}, {16'd0, exp_q[k]});
      end
   endtask

   // mode 0: plain, 1: change hold_cycles mid-hold, 2: stray start pulses while busy
   task automatic run_seq(input string name, input int h, input logic [31:0] exp_cyc, input int mode);
      for (int k = 0; k < wq.size(); k++) push_word(wq[k], (k == wq.size() - 1));
      hold_cycles = HOLD_W'(h);
      pulse_start();
      check({name, "_entry_busy"}, {31'd0, busy}, 32'd1);
      check({name, "_entry_done"}, {31'd0, done}, 32'd0);
      check({name, "_entry_mark"}, {16'd0, checkbits}, 32'h00A5);
      check({name, "_entry_cyc"}, cyc_cnt, 32'd0);
      if (mode == 1) begin
         fork
            monitor(2000);
            begin
               hold_cycles = HOLD_W'(1);
               tick();
               tick();
               hold_cycles = HOLD_W'(h);
            end
         join
      end else if (mode == 2) begin
         fork
            monitor(2000);
            begin
               repeat (3) tick();
               pulse_start();
               repeat (2) tick();
               pulse_start();
            end
         join
      end else begin
         monitor(2000);
      end
      build_expected(h);
      compare_trace(name);
      check({name, "_cyc"}, cyc_cnt, exp_cyc);
      check({name, "_cyc_vs_busy"}, cyc_cnt, nbusy);
      check({name, "_done_mark"}, {16'd0, checkbits}, 32'h005A);
      check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a5_run;

      vecs[0] = '{hold: 4, n: 4, w: {16'h0050, 16'h004A, 16'h0044, 16'h003E}, exp_cyc: 32'd24};
      vecs[1] = '{hold: 0, n: 1, w: {16'h0000, 16'h0000, 16'h0000, 16'h1234}, exp_cyc: 32'd3};
      vecs[2] = '{hold: 1, n: 2, w: {16'h0000, 16'h0000, 16'h0001, 16'hBEEF}, exp_cyc: 32'd4};
      vecs[3] = '{hold: 3, n: 3, w: {16'h0000, 16'h7777, 16'h005A, 16'h00A5}, exp_cyc: 32'd15};
      vecs[4] = '{hold: 2, n: 4, w: {16'h1357, 16'h8001, 16'h0000, 16'hFFFF}, exp_cyc: 32'd12};

      // reset state
      axis_rst_n = 1'b0;
      repeat (2) tick();
      check("rst_checkbits", {16'd0, checkbits}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_s_ready", {31'd0, s_ready}, 32'd0);
      check("rst_io_oeb", {16'd0, io_oeb}, 32'h0000FFFF);
      check("rst_cyc", cyc_cnt, 32'd0);
      axis_rst_n = 1'b1;
      tick();
      check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
      check("post_rst_io_oeb", {16'd0, io_oeb}, 32'd0);

      // table-driven sequences; row 0 also changes hold_cycles mid-hold
      for (int r = 0; r < 5; r++) begin
         wq.delete();
         for (int k = 0; k < vecs[r].n; k++) wq.push_back(vecs[r].w[k]);
         run_seq($sformatf("vec%0d", r), vecs[r].hold, vecs[r].exp_cyc, (r == 0) ? 1 : 0);
      end

      // randomized sequences against the reference
      for (int it = 0; it < 8; it++) begin
         int h;
         int n;
         h = $urandom_range(0, 5);
         n = $urandom_range(1, DEPTH);
         wq.delete();
         for (int k = 0; k < n; k++) wq.push_back(16'($urandom));
         repeat ($urandom_range(0, 3)) tick();
         run_seq($sformatf("rand%0d", it), h, 32'(((h == 0) ? 1 : h) * (n + 2)), 0);
      end

      // stray starts while busy are ignored; start from DONE restarts
      wq.delete();
      wq.push_back(16'h1111);
      wq.push_back(16'h2222);
      run_seq("stray_start", 2, 32'd8, 2);
      repeat (3) tick();
      check("done_hold_cyc", cyc_cnt, 32'd8);
      check("done_hold_flag", {31'd0, done}, 32'd1);
      check("done_hold_mark", {16'd0, checkbits}, 32'h005A);
      wq.delete();
      wq.push_back(16'h3333);
      run_seq("restart", 2, 32'd6, 0);

      // FIFO fills in DONE/IDLE, back-pressure, then drains in order
      hold_cycles = HOLD_W'(1);
      wq.delete();
      for (int k = 0; k < 6; k++) wq.push_back(16'h0100 + 16'(k));
      for (int k = 0; k < 4; k++) push_word(wq[k], 1'b0);
      s_valid = 1'b1;
      s_data  = wq[4];
      check("full_ready", {31'd0, s_ready}, 32'd0);
      tick();
      check("full_ready_hold", {31'd0, s_ready}, 32'd0);
      fork
         begin
            push_word(wq[4], 1'b0);
            push_word(wq[5], 1'b1);
         end
         begin
            pulse_start();
            monitor(500);
         end
      join
      build_expected(1);
      collapse();
      trace = runs;
      compare_trace("drain_order");
      check("drain_cyc_vs_busy", cyc_cnt, nbusy);

      // empty FIFO at start: START_MARK stays up through WAIT
      hold_cycles = HOLD_W'(2);
      pulse_start();
      fork
         monitor(500);
         begin
            repeat (10) tick();
            push_word(16'h1234, 1'b1);
         end
      join
      a5_run = 0;
      while (a5_run < trace.size() && trace[a5_run] == 16'h00A5) a5_run++;
      check("gap_a5_cycles", a5_run, 32'd12);
      check("gap_cyc", cyc_cnt, 32'd16);
      collapse();
      trace = runs;
      exp_q.delete();
      exp_q.push_back(16'h00A5);
      exp_q.push_back(16'h1234);
      exp_q.push_back(16'h005A);
      compare_trace("gap_order");

      // reset while showing data aborts and flushes
      wq.delete();
      wq.push_back(16'h0AAA);
      wq.push_back(16'h0BBB);
      push_word(wq[0], 1'b0);
      push_word(wq[1], 1'b1);
      hold_cycles = HOLD_W'(3);
      pulse_start();
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 50 && !seen; i++) begin
            if (checkbits == 16'h0AAA) seen = 1'b1;
            else tick();
         end
         check("show_reached", {31'd0, seen}, 32'd1);
      end
      axis_rst_n = 1'b0;
      tick();
      check("abort_checkbits", {16'd0, checkbits}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_s_ready", {31'd0, s_ready}, 32'd0);
      check("abort_cyc", cyc_cnt, 32'd0);
      check("abort_io_oeb", {16'd0, io_oeb}, 32'h0000FFFF);
      axis_rst_n = 1'b1;
      tick();
      check("abort_ready_back", {31'd0, s_ready}, 32'd1);
      repeat (3) tick();
      check("abort_no_marker", {16'd0, checkbits}, 32'd0);
      wq.delete();
      wq.push_back(16'h0CCC);
      run_seq("replay", 1, 32'd3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
